// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - SRAM memory-bus responder; optional MEM_RSP_PERF_EN adds perf counters
module mem_bus_responder #(
    parameter int DATA_SIZE     = 4,
    parameter int ADDR_WIDTH    = 10,
    parameter int TAG_WIDTH     = 8,
    parameter int FLAGS_WIDTH   = 1,
    parameter int LATENCY       = 2,
    parameter int QUEUE_SIZE    = 4,
    parameter int PERF_CTR_BITS = 44
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic                     req_rw,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    input  logic [DATA_SIZE-1:0]     req_byteen,
    input  logic [DATA_SIZE*8-1:0]   req_data,
    input  logic [FLAGS_WIDTH-1:0]   req_flags,
    input  logic [TAG_WIDTH-1:0]     req_tag,
    output logic                     req_ready,
    output logic                     rsp_valid,
    output logic [DATA_SIZE*8-1:0]   rsp_data,
    output logic [TAG_WIDTH-1:0]     rsp_tag,
    input  logic                     rsp_ready
`ifdef MEM_RSP_PERF_EN
    ,
    output logic [PERF_CTR_BITS-1:0] perf_reads,
    output logic [PERF_CTR_BITS-1:0] perf_writes,
    output logic [PERF_CTR_BITS-1:0] perf_stalls
`endif
);

    localparam int DW    = DATA_SIZE * 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = $clog2(QUEUE_SIZE + 1);
    localparam int PTRW  = (QUEUE_SIZE > 1) ? $clog2(QUEUE_SIZE) : 1;

    logic [DW-1:0]        mem [DEPTH];

    logic [LATENCY-1:0]   pipe_valid;
    logic [TAG_WIDTH-1:0] pipe_tag  [LATENCY];
    logic [DW-1:0]        pipe_data [LATENCY];

    logic [TAG_WIDTH-1:0] fifo_tag  [QUEUE_SIZE];
    logic [DW-1:0]        fifo_data [QUEUE_SIZE];
    logic [PTRW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]        fifo_count;
    logic [CW-1:0]        pending;

    logic rsp_fire, req_fire, rd_accept, wr_accept;
    logic last_valid, fifo_empty, fifo_push, fifo_pop;
    logic unused_flags;

    assign unused_flags = ^req_flags;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(QUEUE_SIZE - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready looks at this cycle's response fire so a full queue reopens without a bubble.
    assign rsp_fire  = rsp_valid & rsp_ready;
    assign req_ready = reset & ((pending - CW'(rsp_fire)) < CW'(QUEUE_SIZE));
    assign req_fire  = req_valid & req_ready;
    assign rd_accept = req_fire & ~req_rw;
    assign wr_accept = req_fire & req_rw;

    assign last_valid = pipe_valid[LATENCY-1];
    assign fifo_empty = (fifo_count == '0);

    // Empty queue: the pipeline's last stage is presented directly at the head.
    assign rsp_valid = ~fifo_empty | last_valid;
    assign rsp_tag   = fifo_empty ? pipe_tag[LATENCY-1]  : fifo_tag[rd_ptr];
    assign rsp_data  = fifo_empty ? pipe_data[LATENCY-1] : fifo_data[rd_ptr];

    assign fifo_push = last_valid & ~(fifo_empty & rsp_ready);
    assign fifo_pop  = ~fifo_empty & rsp_ready;

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int b = 0; b < DATA_SIZE; b++) begin
                if (req_byteen[b]) begin
                    mem[req_addr][b*8 +: 8] <= req_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_tag[i]  <= '0;
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= rd_accept;
            if (rd_accept) begin
                pipe_tag[0]  <= req_tag;
                pipe_data[0] <= mem[req_addr];
            end
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                if (pipe_valid[i-1]) begin
                    pipe_tag[i]  <= pipe_tag[i-1];
                    pipe_data[i] <= pipe_data[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            pending    <= '0;
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                fifo_tag[i]  <= '0;
                fifo_data[i] <= '0;
            end
        end else begin
            if (fifo_push) begin
                fifo_tag[wr_ptr]  <= pipe_tag[LATENCY-1];
                fifo_data[wr_ptr] <= pipe_data[LATENCY-1];
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (fifo_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            fifo_count <= fifo_count + CW'(fifo_push) - CW'(fifo_pop);
            pending    <= pending + CW'(rd_accept) - CW'(rsp_fire);
        end
    end

`ifndef SYNTHESIS
    overflow_chk: assert property (@(posedge clk) disable iff (!reset)
        (fifo_push && !fifo_pop) |-> (fifo_count < CW'(QUEUE_SIZE)));
`endif

`ifdef MEM_RSP_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_reads  <= '0;
            perf_writes <= '0;
            perf_stalls <= '0;
        end else begin
            if (rd_accept && !(&perf_reads)) begin
                perf_reads <= perf_reads + 1'b1;
            end
            if (wr_accept && !(&perf_writes)) begin
                perf_writes <= perf_writes + 1'b1;
            end
            if (req_valid && !req_ready && !(&perf_stalls)) begin
                perf_stalls <= perf_stalls + 1'b1;
            end
        end
    end
`else
    localparam int unused_perf_bits = PERF_CTR_BITS;
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - randomized self-checking bench with in-order response scoreboard
module tb_mem_bus_responder;

    localparam int LAT = 2;
    localparam int QS  = 4;
    localparam int PCB = 44;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_rw;
    logic [9:0]  req_addr;
    logic [3:0]  req_byteen;
    logic [31:0] req_data;
    logic [0:0]  req_flags;
    logic [7:0]  req_tag;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [7:0]  rsp_tag;
    logic        rsp_ready;
`ifdef MEM_RSP_PERF_EN
    logic [PCB-1:0] perf_reads, perf_writes, perf_stalls;
`endif

    mem_bus_responder #(
        .DATA_SIZE(4), .ADDR_WIDTH(10), .TAG_WIDTH(8), .FLAGS_WIDTH(1),
        .LATENCY(LAT), .QUEUE_SIZE(QS), .PERF_CTR_BITS(PCB)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
        .req_byteen(req_byteen), .req_data(req_data), .req_flags(req_flags),
        .req_tag(req_tag), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .rsp_ready(rsp_ready)
`ifdef MEM_RSP_PERF_EN
        , .perf_reads(perf_reads), .perf_writes(perf_writes), .perf_stalls(perf_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  tag;
        logic [31:0] data;
    } rsp_t;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] model_mem [int];
    rsp_t        exp_q [$];

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_read(input logic [9:0] a, input logic [7:0] t);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = a; req_tag = t;
        req_byteen = 4'h0; req_data = 32'h0;
    endtask

    task automatic write_word(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        logic acc;
        logic [31:0] old_w;
        req_valid = 1'b1; req_rw = 1'b1; req_addr = a; req_data = d; req_byteen = be; req_tag = 8'h0;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            #1; acc = req_ready;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!acc) begin
            n_err++;
            $display("FAIL write_accept addr=%h: accepted=%0b required=1", a, acc);
        end else begin
            old_w = model_mem.exists(int'(a)) ? model_mem[int'(a)] : 32'h0;
            model_mem[int'(a)] = merge_bytes(old_w, d, be);
        end
        req_valid = 1'b0; req_rw = 1'b0;
    endtask

    task automatic wait_rsp(output logic got, input int limit);
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            #1;
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_byteen = '0;
        req_data = '0; req_flags = '0; req_tag = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        n_cmp++; if (rsp_data !== 32'h0) begin n_err++; $display("FAIL reset_rsp_data got=%h want=0", rsp_data); end
        n_cmp++; if (rsp_tag !== 8'h0) begin n_err++; $display("FAIL reset_rsp_tag got=%h want=0", rsp_tag); end
        reset = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready got=%b want=1", req_ready); end
        tick();
    endtask

    task automatic test_write_read();
        rsp_ready = 1'b1;
        write_word(10'h010, 32'hDEADBEEF, 4'hF);
        set_read(10'h010, 8'h5A);
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL wr_rd_ready got=%b want=1", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL latency_early got=%b want=0", rsp_valid); end
        @(posedge clk); #1;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF || rsp_tag !== 8'h5A) begin
            n_err++;
            $display("FAIL wr_rd_rsp got v=%b d=%h t=%h want v=1 d=deadbeef t=5a", rsp_valid, rsp_data, rsp_tag);
        end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL wr_rd_after_fire got=%b want=0", rsp_valid); end
    endtask

    task automatic test_byteen();
        logic got;
        rsp_ready = 1'b1;
        write_word(10'h020, 32'h11223344, 4'hF);
        write_word(10'h020, 32'hAABBCCDD, 4'h5);
        set_read(10'h020, 8'h21);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_rsp(got, 10);
        n_cmp++;
        if (!got || rsp_data !== 32'h11BB33DD || rsp_tag !== 8'h21) begin
            n_err++;
            $display("FAIL byteen_merge got v=%b d=%h t=%h want v=1 d=11bb33dd t=21", got, rsp_data, rsp_tag);
        end
        n_cmp++;
        if (rsp_data !== model_mem[32'h020]) begin
            n_err++; $display("FAIL byteen_model got=%h want=%h", rsp_data, model_mem[32'h020]);
        end
        tick();
    endtask

    task automatic test_full();
        logic got;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_read(10'h010, 8'(i));
            #1;
            n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL full_accept%0d got=%b want=1", i, req_ready); end
            @(posedge clk); #1;
        end
        set_read(10'h010, 8'd4);
        #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL full_block got=%b want=0", req_ready); end
        repeat (3) begin
            @(posedge clk); #1; #1;
            n_cmp++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_tag !== 8'd0) begin
                n_err++;
                $display("FAIL full_hold got rdy=%b v=%b t=%h want rdy=0 v=1 t=00", req_ready, rsp_valid, rsp_tag);
            end
        end
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL full_reopen got=%b want=1", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            #1;
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_tag !== 8'(k)) begin
                n_err++; $display("FAIL full_order%0d got v=%b t=%h want v=1 t=%h", k, rsp_valid, rsp_tag, 8'(k));
            end
            @(posedge clk); #1;
        end
        wait_rsp(got, 10);
        n_cmp++;
        if (!got || rsp_tag !== 8'd4 || rsp_data !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL full_fifth got v=%b t=%h d=%h want v=1 t=04 d=deadbeef", got, rsp_tag, rsp_data);
        end
        tick();
    endtask

    task automatic test_stream();
        int first_cyc, last_cyc, idx;
        rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) write_word(10'(32'h200 + i), $urandom, 4'hF);
        first_cyc = -1; last_cyc = -1; idx = 0;
        for (int cyc = 0; cyc < 16 + LAT + 4; cyc++) begin
            if (cyc < 16) set_read(10'(32'h200 + cyc), 8'(32'h80 + cyc));
            else req_valid = 1'b0;
            #1;
            if (cyc < 16) begin
                n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready%0d got=%b want=1", cyc, req_ready); end
            end
            if (rsp_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                n_cmp++;
                if (idx >= 16 || rsp_tag !== 8'(32'h80 + idx) || rsp_data !== model_mem[32'h200 + idx]) begin
                    n_err++; $display("FAIL stream_rsp%0d got t=%h d=%h", idx, rsp_tag, rsp_data);
                end
                idx++;
            end
            @(posedge clk); #1;
        end
        n_cmp++; if (first_cyc !== LAT) begin n_err++; $display("FAIL stream_latency got=%0d want=%0d", first_cyc, LAT); end
        n_cmp++;
        if (idx !== 16 || last_cyc - first_cyc !== 15) begin
            n_err++; $display("FAIL stream_bubbles got n=%0d span=%0d want n=16 span=15", idx, last_cyc - first_cyc);
        end
    endtask

    task automatic test_random();
        logic fire, exp_rdy, stalled;
        logic [7:0] h_tag;
        logic [31:0] h_data;
        rsp_t e;
        rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) write_word(10'(32'h100 + i), $urandom, 4'hF);
        stalled = 1'b0; h_tag = '0; h_data = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            req_valid  = ($urandom_range(0, 9) < 7);
            req_rw     = ($urandom_range(0, 9) < 3);
            req_addr   = 10'(32'h100 + $urandom_range(0, 15));
            req_byteen = 4'($urandom_range(0, 15));
            req_data   = $urandom;
            req_tag    = 8'($urandom);
            req_flags  = 1'($urandom);
            rsp_ready  = ($urandom_range(0, 9) < 6);
            #1;
            fire    = rsp_valid && rsp_ready;
            exp_rdy = ((exp_q.size() - int'(fire)) < QS);
            n_cmp++;
            if (req_ready !== exp_rdy) begin
                n_err++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", cyc, req_ready, exp_rdy);
            end
            if (stalled) begin
                n_cmp++;
                if (rsp_valid !== 1'b1 || rsp_tag !== h_tag || rsp_data !== h_data) begin
                    n_err++; $display("FAIL rand_hold cyc=%0d got t=%h d=%h want t=%h d=%h", cyc, rsp_tag, rsp_data, h_tag, h_data);
                end
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL rand_spurious cyc=%0d got v=1 want v=0", cyc);
                end else if (fire) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (rsp_tag !== e.tag || rsp_data !== e.data) begin
                        n_err++; $display("FAIL rand_rsp cyc=%0d got t=%h d=%h want t=%h d=%h", cyc, rsp_tag, rsp_data, e.tag, e.data);
                    end
                end
            end
            stalled = rsp_valid && !rsp_ready;
            h_tag = rsp_tag; h_data = rsp_data;
            if (req_valid && req_ready) begin
                if (req_rw) model_mem[int'(req_addr)] = merge_bytes(model_mem[int'(req_addr)], req_data, req_byteen);
                else exp_q.push_back({req_tag, model_mem[int'(req_addr)]});
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            #1;
            if (rsp_valid) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (rsp_tag !== e.tag || rsp_data !== e.data) begin
                    n_err++; $display("FAIL drain_rsp got t=%h d=%h want t=%h d=%h", rsp_tag, rsp_data, e.tag, e.data);
                end
            end
            @(posedge clk); #1;
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL drain_left got=%0d want=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_reset_midop();
        int got;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_read(10'h010, 8'(32'h40 + i));
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_data !== 32'h0 || rsp_tag !== 8'h0) begin
            n_err++; $display("FAIL midop_reset got v=%b rdy=%b d=%h t=%h want all 0", rsp_valid, req_ready, rsp_data, rsp_tag);
        end
        tick(); tick();
        reset = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL midop_ready got=%b want=1", req_ready); end
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL midop_stale cyc=%0d got=%b want=0", i, rsp_valid); end
        end
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_read(10'h010, 8'(32'h60 + i));
            #1;
            n_cmp++;
            if (req_ready !== (i < 4)) begin n_err++; $display("FAIL midop_credit%0d got=%b want=%b", i, req_ready, (i < 4)); end
            if (i < 4) begin @(posedge clk); #1; end
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (rsp_valid) begin
                n_cmp++;
                if (rsp_tag !== 8'(32'h60 + got) || rsp_data !== 32'hDEADBEEF) begin
                    n_err++; $display("FAIL midop_rsp got t=%h d=%h want t=%h d=deadbeef", rsp_tag, rsp_data, 8'(32'h60 + got));
                end
                got++;
            end
            @(posedge clk); #1;
        end
        n_cmp++; if (got !== 4) begin n_err++; $display("FAIL midop_count got=%0d want=4", got); end
    endtask

`ifdef MEM_RSP_PERF_EN
    task automatic test_perf();
        req_valid = 1'b0; rsp_ready = 1'b0;
        reset = 1'b0; tick(); tick(); reset = 1'b1; #1;
        n_cmp++;
        if (perf_reads !== '0 || perf_writes !== '0 || perf_stalls !== '0) begin
            n_err++; $display("FAIL perf_reset got r=%0d w=%0d s=%0d want 0", perf_reads, perf_writes, perf_stalls);
        end
        for (int i = 0; i < 4; i++) begin set_read(10'h010, 8'(i)); @(posedge clk); #1; end
        set_read(10'h010, 8'd4);
        repeat (4) begin @(posedge clk); #1; end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        set_read(10'h010, 8'd5);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (10) tick();
        for (int i = 0; i < 3; i++) write_word(10'(32'h300 + i), $urandom, 4'hF);
        #1;
        n_cmp++; if (perf_reads !== PCB'(6)) begin n_err++; $display("FAIL perf_reads got=%0d want=6", perf_reads); end
        n_cmp++; if (perf_writes !== PCB'(3)) begin n_err++; $display("FAIL perf_writes got=%0d want=3", perf_writes); end
        n_cmp++; if (perf_stalls !== PCB'(4)) begin n_err++; $display("FAIL perf_stalls got=%0d want=4", perf_stalls); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_byteen();
        test_full();
        test_stream();
        test_random();
        test_reset_midop();
`ifdef MEM_RSP_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
